pow_calc: RTL and testbench
===========================

# pow_calc

Iterative integer exponentiation unit computing `base`^`exponent` mod 2^WIDTH with a start/done handshake and true-overflow flag. It is the inverse companion of the team's iterative logarithm block, which counts multiplications until a threshold is reached. pow_calc instead raises a base to a given power using LSB-first square-and-multiply. It sits on the same datapath and is driven by the same controller-style start/done protocol.

## Interface
- WIDTH, 16, width of base, exponent and result
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- base  in  WIDTH  operand b, captured when start accepted
- exponent  in  WIDTH  operand e, captured when start accepted
- result  out  WIDTH  b^e mod 2^WIDTH; held until next accepted start
- overflow  out  1  true b^e ≥ 2^WIDTH; valid with done, held with result
- busy  out  1  high in CALC and FIN
- done  out  1  one-cycle pulse, high in FIN

## Operation
- States:
  - IDLE: on start=1, load acc←1, b←base, e←exponent, bovf←0, overflow←0.
    - Go to FIN if exponent==0; otherwise go to CALC.
  - CALC: one exponent bit per cycle, all updates in parallel.
    - If e[0]: acc←low(acc·b); overflow |= (high(acc·b)≠0) | bovf.
    - If (e>>1)≠0: b←low(b·b); bovf |= high(b·b)≠0. No squaring is done on the final step, so an unused square never flags overflow.
    - e←e>>1.
    - Go to FIN when (e>>1)==0.
  - FIN: done=1, result=acc. Go to IDLE unconditionally.
- Products are full 2·WIDTH bits. low = bits [WIDTH-1:0]; high = bits [2·WIDTH-1:WIDTH].
- overflow is sticky within one operation and cleared on the next accepted start.
- 0^0 = 1 with overflow=0. 0^e for e>0 is 0 with overflow=0.
- start in CALC or FIN is ignored; it is not queued. start held high across FIN is re-accepted in the following IDLE cycle.
- result is driven from acc at all times.

## Timing
- Reset values: state=IDLE, result (acc)=0, overflow=0, busy=0, done=0. Internal b, e and bovf are cleared to 0.
- Reset mid-operation aborts immediately, with no done pulse.
- Let n = bit length of exponent (index of MSB set + 1). Start is sampled at edge t0.
  - n≥1: CALC occupies edges t0+1..t0+n; done is high for exactly the cycle following edge t0+n.
  - n=0: done is high in the cycle following t0.
- Worst case (e=2^WIDTH−1): done follows edge t0+WIDTH.
- result and overflow are valid while done=1 and stable until the edge after the next accepted start.
- busy rises at t0 and falls on the edge that leaves FIN.

## Structure
- Package pow_pkg:
  - state enum {IDLE, CALC, FIN}, 2-bit encoding;
  - default WIDTH constant.
- Sub-module mul_ovf (combinational, parameter WIDTH): inputs a, b; outputs low[WIDTH] and ovf (high bits nonzero). Instantiated twice, once for acc·b and once for b·b.
- Top: FSM plus acc, b, e, bovf and overflow registers.

## Test plan
- base=3, exponent=4 → n=3: done high after edge t0+3, result=81, overflow=0, done exactly one cycle.
- base=2, exponent=16 (WIDTH=16) → result=0, overflow=1. Then base=255, exponent=2 → result=65025, overflow=0.
- base=0, exponent=0 → done in the cycle after t0, result=1, overflow=0. Also base=300, exponent=1 → result=300, overflow=0 (no squaring done).
- base=1, exponent=65535 → done after edge t0+16, result=1, overflow=0, busy high for the whole run.
- start pulsed during CALC with different operands → ignored; result matches the first operands only.
- rst asserted mid-CALC (base=5, exponent=9) → all outputs 0 immediately with no done. A new start (5, 3) after reset release → result=125.

Source files
------------

// File: rtl/pow_pkg.sv
// Shared types and defaults for the iterative exponentiation unit.
package pow_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/pow_calc_mul_ovf.sv
// Full-width multiply split into the low word and a flag for any nonzero high bits.
module mul_ovf #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] low,
  output logic             ovf
);

  logic [2*WIDTH-1:0] w_prod;

  assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign low    = w_prod[WIDTH-1:0];
  assign ovf    = |w_prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/pow_calc.sv
// LSB-first square-and-multiply exponentiation, one exponent bit per cycle.
// Handshake: start is only sampled in IDLE; done pulses for one cycle in FIN with result/overflow valid.
module pow_calc
  import pow_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [1:0]       o_state
);

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_e;
  logic             r_bovf;
  logic             r_ovf;

  logic [WIDTH-1:0] w_acc_low;
  logic             w_acc_ovf;
  logic [WIDTH-1:0] w_sq_low;
  logic             w_sq_ovf;
  logic [WIDTH-1:0] w_e_next;

  mul_ovf #(.WIDTH(WIDTH)) u_mul_acc (
    .a   (r_acc),
    .b   (r_b),
    .low (w_acc_low),
    .ovf (w_acc_ovf)
  );

  mul_ovf #(.WIDTH(WIDTH)) u_mul_sq (
    .a   (r_b),
    .b   (r_b),
    .low (w_sq_low),
    .ovf (w_sq_ovf)
  );

  assign w_e_next = r_e >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_b     <= '0;
      r_e     <= '0;
      r_bovf  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc   <= WIDTH'(1);
            r_b     <= base;
            r_e     <= exponent;
            r_bovf  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= (exponent == '0) ? ST_FIN : ST_CALC;
          end
        end
        ST_CALC: begin
          // A pending base overflow only matters once that power is multiplied in.
          if (r_e[0]) begin
            r_acc <= w_acc_low;
            r_ovf <= r_ovf | w_acc_ovf | r_bovf;
          end
          if (w_e_next != '0) begin
            r_b    <= w_sq_low;
            r_bovf <= r_bovf | w_sq_ovf;
          end
          r_e <= w_e_next;
          if (w_e_next == '0) begin
            r_state <= ST_FIN;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign result   = r_acc;
  assign overflow = r_ovf;
  assign busy     = (r_state == ST_CALC) || (r_state == ST_FIN);
  assign done     = (r_state == ST_FIN);
  assign o_state  = r_state;

endmodule

// File: tb/tb_pow_calc.sv
// Directed bench for pow_calc: table of operands with hand-computed results plus corner sequences.
module tb_pow_calc;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base;
  logic [15:0] exponent;
  logic [15:0] result;
  logic        overflow;
  logic        busy;
  logic        done;
  logic [1:0]  o_state;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [15:0] b;
    logic [15:0] e;
    logic [15:0] res;
    logic        ovf;
    int          n;
  } vec_t;

  vec_t vecs[13];

  pow_calc #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .result   (result),
    .overflow (overflow),
    .busy     (busy),
    .done     (done),
    .o_state  (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issues one start, then samples on falling edges until done (bounded).
  // lat counts falling edges from the accept edge to the first one with done high.
  task automatic run_op(input logic [15:0] b, input logic [15:0] e,
                        output int lat, output logic [15:0] res,
                        output logic ovf, output int busy_bad);
    @(negedge clk);
    base     = b;
    exponent = e;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_bad = busy ? 0 : 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!busy) busy_bad++;
    end
    res = result;
    ovf = overflow;
  endtask

  initial begin
    int          lat;
    int          busy_bad;
    logic [15:0] res;
    logic        ovf;
    int          done_seen;

    n_checks = 0;
    n_errors = 0;
    start    = 1'b0;
    base     = '0;
    exponent = '0;

    vecs[0]  = '{16'd3,     16'd4,     16'd81,    1'b0, 3};
    vecs[1]  = '{16'd2,     16'd16,    16'd0,     1'b1, 5};
    vecs[2]  = '{16'd255,   16'd2,     16'd65025, 1'b0, 2};
    vecs[3]  = '{16'd0,     16'd0,     16'd1,     1'b0, 0};
    vecs[4]  = '{16'd300,   16'd1,     16'd300,   1'b0, 1};
    vecs[5]  = '{16'd1,     16'd65535, 16'd1,     1'b0, 16};
    vecs[6]  = '{16'd256,   16'd2,     16'd0,     1'b1, 2};
    vecs[7]  = '{16'd0,     16'd5,     16'd0,     1'b0, 3};
    vecs[8]  = '{16'd7,     16'd3,     16'd343,   1'b0, 2};
    vecs[9]  = '{16'd2,     16'd15,    16'd32768, 1'b0, 4};
    vecs[10] = '{16'd3,     16'd11,    16'd46075, 1'b1, 4};
    vecs[11] = '{16'd16,    16'd4,     16'd0,     1'b1, 3};
    vecs[12] = '{16'd65535, 16'd2,     16'd1,     1'b1, 2};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result",   32'(result),   32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_busy",     32'(busy),     32'd0);
    check("reset_done",     32'(done),     32'd0);
    check("reset_state",    32'(o_state),  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].b, vecs[i].e, lat, res, ovf, busy_bad);
      check($sformatf("v%0d_latency", i),  32'(lat),  32'(vecs[i].n + 1));
      check($sformatf("v%0d_result", i),   32'(res),  32'(vecs[i].res));
      check($sformatf("v%0d_overflow", i), 32'(ovf),  32'(vecs[i].ovf));
      check($sformatf("v%0d_busy", i),     32'(busy_bad), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_idle_busy", i),  32'(busy), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_hold", i), 32'({overflow, result}), 32'({vecs[i].ovf, vecs[i].res}));
    end

    // start pulsed with other operands during CALC must be ignored
    @(negedge clk);
    base = 16'd3; exponent = 16'd4; start = 1'b1;
    @(negedge clk);
    base = 16'd5; exponent = 16'd5;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignore_start_latency", 32'(lat), 32'd4);
    check("ignore_start_result",  32'(result), 32'd81);
    check("ignore_start_ovf",     32'(overflow), 32'd0);
    @(negedge clk);
    check("ignore_start_not_queued", 32'(busy), 32'd0);

    // reset in the middle of CALC aborts with no done pulse
    @(negedge clk);
    base = 16'd5; exponent = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midcalc_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_result",   32'(result),   32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_done",     32'(done),     32'd0);
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    run_op(16'd5, 16'd3, lat, res, ovf, busy_bad);
    check("after_reset_latency",  32'(lat), 32'd3);
    check("after_reset_result",   32'(res), 32'd125);
    check("after_reset_overflow", 32'(ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
